lsu_mem_cycle: RTL

- Memory-stage load/store unit for the 5-stage RV32I pipeline.
- Takes the M-stage memory op and drives the data-memory request/grant/response bus.
- Stalls the pipeline while the access is in flight.
- Returns aligned, sign/zero-extended load data on o_ld_data_M, which feeds the writeback select mux as its load-data input.

---
 rtl/lsu_mem_cycle.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_cycle.sv
// Memory-stage load/store unit: turns the M-stage memory op into one data-bus
// transaction, stalls the pipeline while it is in flight and formats load data.
module lsu_mem_cycle #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_valid_M,
  input  logic        i_mem_we_M,
  input  logic [2:0]  i_funct3_M,
  input  logic [31:0] i_addr_M,
  input  logic [31:0] i_st_data_M,
  output logic        o_stall_M,
  output logic [31:0] o_ld_data_M,
  output logic        o_ld_valid_M,
  output logic        o_misalign_M,
  output logic        o_bus_err_M,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q, wdata_q, ld_data_q;
  logic [3:0]  be_q;
  logic        ld_valid_q, bus_err_q;

  logic        legal, is_half, is_word, bad_op, in_idle, accept, expire;
  logic        capture, abort;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ld_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign legal   = i_mem_we_M ? (i_funct3_M inside {3'b000, 3'b001, 3'b010})
                              : (i_funct3_M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_half = (i_funct3_M[1:0] == 2'b01);
  assign is_word = (i_funct3_M[1:0] == 2'b10);
  assign bad_op  = ~legal | (is_half & i_addr_M[0]) | (is_word & (i_addr_M[1:0] != 2'b00));
  assign in_idle = (state == S_IDLE);
  assign o_misalign_M = i_mem_valid_M & in_idle & bad_op;
  assign accept  = i_mem_valid_M & in_idle & ~bad_op & ~i_rst;
  // >= rather than == so a grant taken on the expiry cycle still gives WAIT one chance
  assign expire  = (cnt >= 8'(TIMEOUT - 1));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = '0;
    if (i_mem_we_M) begin
      case (i_funct3_M[1:0])
        2'b00: begin
          be_new    = 4'b0001 << i_addr_M[1:0];
          wdata_new = {4{i_st_data_M[7:0]}};
        end
        2'b01: begin
          be_new    = i_addr_M[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{i_st_data_M[15:0]}};
        end
        default: wdata_new = i_st_data_M;
      endcase
    end
  end

  assign byte_sel = i_dmem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_fmt = {24'b0, byte_sel};
      3'b101:  ld_fmt = {16'b0, half_sel};
      default: ld_fmt = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    o_dmem_req = 1'b0;
    o_stall_M  = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        o_stall_M = accept;
        if (accept) state_nxt = S_REQ;
      end
      S_REQ: begin
        o_dmem_req = 1'b1;
        o_stall_M  = 1'b1;
        if (i_dmem_gnt) begin
          state_nxt = we_q ? S_DONE : S_WAIT;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        o_stall_M = 1'b1;
        if (i_dmem_rvalid) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      ld_valid_q <= capture;
      bus_err_q  <= abort;
      if (accept) begin
        we_q    <= i_mem_we_M;
        f3_q    <= i_funct3_M;
        off_q   <= i_addr_M[1:0];
        addr_q  <= {i_addr_M[31:2], 2'b00};
        wdata_q <= wdata_new;
        be_q    <= be_new;
        cnt     <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (capture) ld_data_q <= ld_fmt;
      else if (abort) ld_data_q <= '0;
    end
  end

  assign o_dmem_we    = we_q & (state == S_REQ);
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_be    = be_q;
  assign o_ld_data_M  = ld_data_q;
  assign o_ld_valid_M = ld_valid_q;
  assign o_bus_err_M  = bus_err_q;

endmodule
